// File: rtl/a0_trace_pkg.sv
// Shared types and defaults for the a0 trace capture block.
// Optional feature macro: TRACE_TS_EN adds a 32-bit cycle stamp to every entry.
package a0_trace_pkg;

  localparam int unsigned DEFAULT_DEPTH  = 16;
  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned TS_W           = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2
  } trace_state_t;

  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] data;
`ifdef TRACE_TS_EN
    logic [TS_W-1:0]           ts;
`endif
  } trace_entry_t;

endpackage

// File: rtl/a0_trace_capture_if.sv
// Drain port of the trace FIFO: head entry plus valid/ready handshake.
interface a0_trace_capture_if #(
  parameter int unsigned DATA_W = a0_trace_pkg::DEFAULT_DATA_W,
  parameter int unsigned TS_W   = a0_trace_pkg::TS_W
);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TS_W-1:0]   out_ts;

  modport master (
    output out_valid,
    output out_data,
    output out_ts,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_ts,
    output out_ready
  );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries; caller qualifies push/pop, count separates full from empty.
module trace_fifo
  import a0_trace_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  trace_entry_t           din,
  output trace_entry_t           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  trace_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  // Head is shown only while valid so stale storage never leaks onto the port.
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; array is not reset since the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/a0_trace_capture.sv
// Records every change of the CPU a0 register into a drainable trace FIFO.
// Optional feature macro: TRACE_TS_EN stamps each entry with a free-running cycle count.
module a0_trace_capture
  import a0_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      a0_i,
  input  logic                   en_i,
  input  logic                   clear_i,
  a0_trace_capture_if.master     drain,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
);

  trace_state_t      state;
  trace_state_t      state_nxt;
  logic [DATA_W-1:0] last_a0;
  logic              capture;
  logic              push;
  logic              pop;
  logic              drop;
  logic              full;
  logic              empty;
  trace_entry_t      din;
  trace_entry_t      dout;

  // Capture state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and capture decision; clear overrides everything and re-arms on en_i.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (clear_i) begin
      state_nxt = en_i ? ARMED : IDLE;
    end else begin
      case (state)
        IDLE:  if (en_i) state_nxt = ARMED;
        ARMED: begin
          if (en_i) begin
            capture   = 1'b1;
            state_nxt = TRACK;
          end else begin
            state_nxt = IDLE;
          end
        end
        TRACK: begin
          if (!en_i)                 state_nxt = IDLE;
          else if (a0_i != last_a0)  capture   = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign pop  = drain.out_valid & drain.out_ready & ~clear_i;
  assign push = capture & (~full | pop);
  assign drop = capture & ~push;

  // Last captured value and drop accounting; dropped captures still advance last_a0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_a0  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear_i) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (capture) last_a0 <= a0_i;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

`ifdef TRACE_TS_EN
  logic [TS_W-1:0] ts_cnt;

  // Free-running cycle stamp; deliberately untouched by clear_i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_cnt <= '0;
    else      ts_cnt <= ts_cnt + TS_W'(1);
  end

  // Entry assembly with stamp.
  always_comb begin
    din      = '0;
    din.data = a0_i;
    din.ts   = ts_cnt;
  end

  assign drain.out_ts = dout.ts;
`else
  // Entry assembly, data only.
  always_comb begin
    din      = '0;
    din.data = a0_i;
  end

  assign drain.out_ts = '0;
`endif

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear_i),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign drain.out_valid = ~empty;
  assign drain.out_data  = dout.data;

endmodule

// File: tb/tb_a0_trace_capture.sv
// Scoreboard bench for a0_trace_capture: expected entries queued at stimulus, checked on drain.
module tb_a0_trace_capture;
  import a0_trace_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] ts;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [31:0]      a0 = '0;
  logic             en = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [15:0]      drop_cnt;
  logic [31:0]      tb_cyc;

  int   vecs = 0;
  int   errs = 0;
  exp_t exp_q[$];

  a0_trace_capture_if bus ();

  a0_trace_capture #(
    .DEPTH  (DEPTH),
    .DATA_W (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a0_i     (a0),
    .en_i     (en),
    .clear_i  (clear),
    .drain    (bus),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Independent cycle counter used for expected stamps.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_cyc <= 32'd0;
    else      tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic feed(input logic [31:0] v, input logic e, input logic exp_cap);
    exp_t x;
    a0 = v;
    en = e;
    if (exp_cap) begin
      x.data = v;
      x.ts   = tb_cyc;
      exp_q.push_back(x);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag, input int max_n);
    exp_t x;
    bus.out_ready = 1'b1;
    for (int i = 0; i < max_n; i++) begin
      if (bus.out_valid !== 1'b1) break;
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL %s_extra: out_data=%h present, expected nothing", tag, bus.out_data);
      end else begin
        x = exp_q.pop_front();
        if (bus.out_data !== x.data) begin
          errs++;
          $display("FAIL %s_data: got %h want %h", tag, bus.out_data, x.data);
        end
        vecs++;
`ifdef TRACE_TS_EN
        if (bus.out_ts !== x.ts) begin
          errs++;
          $display("FAIL %s_ts: got %0d want %0d", tag, bus.out_ts, x.ts);
        end
`else
        if (bus.out_ts !== 32'd0) begin
          errs++;
          $display("FAIL %s_ts: got %0d want 0", tag, bus.out_ts);
        end
`endif
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    vecs++;
    if (bus.out_valid !== (exp_q.size() != 0)) begin
      errs++;
      $display("FAIL %s_remain: out_valid=%b, %0d entries expected", tag, bus.out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    vecs++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.out_ts !== 32'd0) begin
      errs++;
      $display("FAIL reset_head: valid=%b data=%h ts=%h want 0/0/0", bus.out_valid, bus.out_data, bus.out_ts);
    end
    vecs++;
    if (count !== '0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      errs++;
      $display("FAIL reset_status: count=%0d ovf=%b drop=%0d want 0/0/0", count, overflow, drop_cnt);
    end
  endtask

  task automatic test_hold();
    feed(32'd5, 1'b1, 1'b0);
    feed(32'd5, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) feed(32'd5, 1'b1, 1'b0);
    vecs++;
    if (count !== CNT_W'(1)) begin
      errs++;
      $display("FAIL hold_count: got %0d want 1", count);
    end
    feed(32'd5, 1'b0, 1'b0);
    drain("hold", 4);
  endtask

  task automatic test_sequence();
    feed(32'd1, 1'b1, 1'b0);
    feed(32'd1, 1'b1, 1'b1);
    feed(32'd1, 1'b1, 1'b0);
    feed(32'd2, 1'b1, 1'b1);
    feed(32'd2, 1'b1, 1'b0);
    feed(32'd3, 1'b1, 1'b1);
    vecs++;
    if (count !== CNT_W'(3)) begin
      errs++;
      $display("FAIL seq_count: got %0d want 3", count);
    end
    feed(32'd3, 1'b0, 1'b0);
    drain("seq", 8);
  endtask

  task automatic test_full_pop();
    feed(32'd100, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) feed(32'd100 + 32'(i), 1'b1, 1'b1);
    vecs++;
    if (count !== CNT_W'(16) || overflow !== 1'b0) begin
      errs++;
      $display("FAIL full_fill: count=%0d ovf=%b want 16/0", count, overflow);
    end
    // New value arrives in the same cycle the head is accepted.
    exp_q.push_back('{data: 32'd200, ts: tb_cyc});
    a0 = 32'd200;
    drain("full_pop", 1);
    vecs++;
    if (count !== CNT_W'(16) || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      errs++;
      $display("FAIL full_pop_status: count=%0d ovf=%b drop=%0d want 16/0/0", count, overflow, drop_cnt);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) feed(32'd300 + 32'(i), 1'b1, 1'b0);
    vecs++;
    if (count !== CNT_W'(16) || overflow !== 1'b1 || drop_cnt !== 16'd4) begin
      errs++;
      $display("FAIL ovf_status: count=%0d ovf=%b drop=%0d want 16/1/4", count, overflow, drop_cnt);
    end
  endtask

  task automatic test_clear();
    drain("pre_clear", 12);
    vecs++;
    if (count !== CNT_W'(4) || overflow !== 1'b1) begin
      errs++;
      $display("FAIL pre_clear_status: count=%0d ovf=%b want 4/1", count, overflow);
    end
    clear = 1'b1;
    exp_q.delete();
    feed(32'd77, 1'b1, 1'b0);
    clear = 1'b0;
    vecs++;
    if (count !== '0 || overflow !== 1'b0 || drop_cnt !== 16'd0 || bus.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL clear_status: count=%0d ovf=%b drop=%0d valid=%b want 0/0/0/0",
               count, overflow, drop_cnt, bus.out_valid);
    end
    feed(32'd77, 1'b1, 1'b1);
    vecs++;
    if (count !== CNT_W'(1)) begin
      errs++;
      $display("FAIL clear_recapture: count=%0d want 1", count);
    end
    drain("clear", 4);
  endtask

  task automatic test_back_to_back();
    vecs++;
    if (bus.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_start: out_valid=%b want 0", bus.out_valid);
    end
    feed(32'd500, 1'b1, 1'b1);
    for (int i = 1; i < 8; i++) begin
      exp_q.push_back('{data: 32'd500 + 32'(i), ts: tb_cyc});
      a0 = 32'd500 + 32'(i);
      drain("b2b", 1);
    end
    en = 1'b0;
    drain("b2b_tail", 4);
  endtask

  task automatic test_async_reset();
    feed(32'd1, 1'b1, 1'b0);
    feed(32'd1, 1'b1, 1'b1);
    feed(32'd2, 1'b1, 1'b1);
    feed(32'd3, 1'b1, 1'b1);
    drain("pre_rst", 1);
    bus.out_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    vecs++;
    if (bus.out_valid !== 1'b0 || count !== '0) begin
      errs++;
      $display("FAIL async_rst: valid=%b count=%0d want 0/0", bus.out_valid, count);
    end
    exp_q.delete();
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    feed(32'd3, 1'b1, 1'b0);
    feed(32'd3, 1'b1, 1'b1);
    vecs++;
    if (count !== CNT_W'(1)) begin
      errs++;
      $display("FAIL rst_rearm: count=%0d want 1", count);
    end
    en = 1'b0;
    drain("rst_rearm", 4);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    test_reset();
    test_hold();
    test_sequence();
    test_full_pop();
    test_overflow();
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
